// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data and memory-side signals of the
// shared memory-port arbiter.
//   slave  : the arbiter's view (requests/memory response in, acks/memory cmd out)
//   master : the environment's view (requesters plus backing memory)
// Signals:
//   i_req/i_addr -> i_ack/i_rdata           fetch read channel
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata  data read/write channel
//   mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata  memory port
//   stall_f/stall_a                         pipeline hold requests
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_f;
  logic              stall_a;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output stall_f, stall_a
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  stall_f, stall_a
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle backing-memory port between the
// fetch stage (instruction reads) and the action stage (data reads/writes).
// Each access runs IDLE -> BUSY_I/BUSY_D -> RESP -> IDLE.
// Ports:
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory channels, stalls)
// Build option:
//   MEM_ARB_RR_EN : when defined, a last_grant register alternates the winner
//                   when both sides request in IDLE; otherwise data always wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                prefer_d;
  logic                take_d;

`ifdef MEM_ARB_RR_EN
  // last_d_q = 1 when the data side won the previous grant (reset: fetch)
  logic                last_d_q, last_d_d;
  assign prefer_d = ~last_d_q;
`else
  assign prefer_d = 1'b1;
`endif

  // Data wins a tie only when preferred; an uncontested request always wins.
  assign take_d = bus.d_req & (prefer_d | ~bus.i_req);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (take_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          state_d     = BUSY_D;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end else if (bus.i_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          state_d     = BUSY_I;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end
      end
      BUSY_I: begin
        if (bus.mem_ack) begin
          i_rdata_d = bus.mem_rdata;
          i_ack_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          // Writes leave the last read word in place.
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
          d_ack_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        // Requests are ignored here so requesters can retire or replace them.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  // Stalls are combinational so the pipeline holds in the request cycle;
  // gated by n_rst so they read 0 throughout reset.
  assign bus.stall_f = n_rst & bus.i_req & ~i_ack_q;
  assign bus.stall_a = n_rst & bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Requesters push
// expected read data when they issue; a monitor pops on each ack. A behavioural
// memory with random latency serves the memory port. Honours MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

  logic clk;
  logic n_rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  logic [7:0] mem_arr [256];   // backing memory contents
  logic [7:0] ref_arr [256];   // reference view, updated when requests issue
  logic [7:0] i_q [$];
  logic [7:0] d_q [$];
  logic [7:0] txn_log [$];     // mem_addr of every memory transaction start
  logic [7:0] d_hold = 8'h00;  // expected d_rdata after a data ack
  logic [7:0] i_addr_cur, d_addr_cur, d_wdata_cur;
  logic       d_we_cur;
  bit         chk_sides = 1'b1;
  bit         stray_ack = 1'b0;
  int         mem_delay_force = -1;
  int         last_mem_ack_cyc = 0;
  logic [7:0] ack_addr, ack_wdata;
  logic       ack_we;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural memory: acks after 0..3 cycles (or a forced latency).
  bit         in_txn = 1'b0;
  bit         acked  = 1'b0;
  int         cnt    = 0;
  logic [7:0] t_addr, t_wdata;
  logic       t_we;

  always @(negedge clk) begin
    if (!n_rst) begin
      bus.mem_ack = 1'b0;
      in_txn      = 1'b0;
      acked       = 1'b0;
    end else begin
      bus.mem_ack = 1'b0;
      if (acked) begin
        check("mem_req_drop_after_ack", 32'(bus.mem_req), 0);
        acked  = 1'b0;
        in_txn = 1'b0;
      end else if (bus.mem_req) begin
        if (!in_txn) begin
          in_txn  = 1'b1;
          t_addr  = bus.mem_addr;
          t_we    = bus.mem_we;
          t_wdata = bus.mem_wdata;
          txn_log.push_back(bus.mem_addr);
          cnt = (mem_delay_force >= 0) ? mem_delay_force : int'($urandom_range(0, 3));
          if (chk_sides) begin
            if (bus.mem_addr[7]) begin
              check("mem_addr_d", 32'(bus.mem_addr), 32'(d_addr_cur));
              check("mem_we_d", 32'(bus.mem_we), 32'(d_we_cur));
              if (d_we_cur) check("mem_wdata_d", 32'(bus.mem_wdata), 32'(d_wdata_cur));
            end else begin
              check("mem_addr_i", 32'(bus.mem_addr), 32'(i_addr_cur));
              check("mem_we_i", 32'(bus.mem_we), 0);
            end
          end
        end else begin
          check("mem_addr_stable", 32'(bus.mem_addr), 32'(t_addr));
          check("mem_we_stable", 32'(bus.mem_we), 32'(t_we));
          check("mem_wdata_stable", 32'(bus.mem_wdata), 32'(t_wdata));
        end
        if (cnt == 0) begin
          if (t_we) begin
            mem_arr[t_addr] = t_wdata;
            bus.mem_rdata   = 8'($urandom);
          end else begin
            bus.mem_rdata   = mem_arr[t_addr];
          end
          bus.mem_ack      = 1'b1;
          acked            = 1'b1;
          last_mem_ack_cyc = cyc;
          ack_addr         = t_addr;
          ack_we           = t_we;
          ack_wdata        = t_wdata;
        end else begin
          cnt--;
        end
      end else begin
        in_txn = 1'b0;
        if (stray_ack) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 8'($urandom);
          stray_ack     = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every ack pops and compares one expected word.
  logic i_ack_prev = 1'b0;
  logic d_ack_prev = 1'b0;

  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.i_ack) begin
        check("i_ack_expected", 32'(i_q.size() > 0), 1);
        check("i_ack_one_cycle", 32'(i_ack_prev), 0);
        if (i_q.size() > 0) check("i_rdata", 32'(bus.i_rdata), 32'(i_q.pop_front()));
      end
      if (bus.d_ack) begin
        check("d_ack_expected", 32'(d_q.size() > 0), 1);
        check("d_ack_one_cycle", 32'(d_ack_prev), 0);
        if (d_q.size() > 0) check("d_rdata", 32'(bus.d_rdata), 32'(d_q.pop_front()));
      end
    end
    i_ack_prev = bus.i_ack;
    d_ack_prev = bus.d_ack;
  end

  // Fetch request held until its ack; expected word pushed at issue.
  task automatic do_i(input logic [7:0] a, output int ack_cyc);
    bus.i_addr = a;
    i_addr_cur = a;
    bus.i_req  = 1'b1;
    i_q.push_back(ref_arr[a]);
    ack_cyc = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.i_ack) begin
        ack_cyc = cyc;
        break;
      end
      check("stall_f_wait", 32'(bus.stall_f), 1);
    end
    check("i_ack_seen", 32'(ack_cyc >= 0), 1);
    if (ack_cyc >= 0) check("stall_f_at_ack", 32'(bus.stall_f), 0);
    bus.i_req = 1'b0;
  endtask

  // Data request; writes update the reference and expect d_rdata unchanged.
  task automatic do_d(input logic we, input logic [7:0] a, input logic [7:0] wd,
                      output int ack_cyc);
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    d_we_cur    = we;
    d_addr_cur  = a;
    d_wdata_cur = wd;
    if (we) ref_arr[a] = wd;
    else    d_hold     = ref_arr[a];
    d_q.push_back(d_hold);
    bus.d_req = 1'b1;
    ack_cyc = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.d_ack) begin
        ack_cyc = cyc;
        break;
      end
      check("stall_a_wait", 32'(bus.stall_a), 1);
    end
    check("d_ack_seen", 32'(ack_cyc >= 0), 1);
    if (ack_cyc >= 0) check("stall_a_at_ack", 32'(bus.stall_a), 0);
    bus.d_req = 1'b0;
  endtask

  int c0, c1, c2, dc, ic;
  logic exp_d;

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem_arr[k] = 8'(k) ^ 8'h5A;
      ref_arr[k] = 8'(k) ^ 8'h5A;
    end
    n_rst = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 8'h00;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    idle(3);

    // Reset values, stalls suppressed even with requests high
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_i_ack", 32'(bus.i_ack), 0);
    check("rst_d_ack", 32'(bus.d_ack), 0);
    check("rst_i_rdata", 32'(bus.i_rdata), 0);
    check("rst_d_rdata", 32'(bus.d_rdata), 0);
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    #1;
    check("rst_stall_f", 32'(bus.stall_f), 0);
    check("rst_stall_a", 32'(bus.stall_a), 0);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    idle(2);

    // Single fetch, memory latency 3
    mem_arr[8'h12] = 8'hA5; ref_arr[8'h12] = 8'hA5;
    mem_delay_force = 3;
    do_i(8'h12, c0);
    check("fetch_ack_after_mem_ack", 32'(c0 - last_mem_ack_cyc), 1);
    check("fetch_i_rdata_a5", 32'(bus.i_rdata), 32'h A5);
    idle(2);

    // Data read then write: write leaves d_rdata alone
    chk_sides = 1'b0;
    mem_delay_force = 2;
    do_d(1'b0, 8'h41, 8'h00, c0);
    idle(2);
    do_d(1'b1, 8'h40, 8'h3C, c0);
    check("write_mem_we", 32'(ack_we), 1);
    check("write_mem_addr", 32'(ack_addr), 32'h40);
    check("write_mem_wdata", 32'(ack_wdata), 32'h3C);
    idle(2);
    do_d(1'b0, 8'h40, 8'h00, c0);
    idle(2);
    chk_sides = 1'b1;

    // Collision with zero-wait memory: data first, fetch after
    mem_delay_force = 0;
    d_addr_cur = 8'h90; d_we_cur = 1'b0; i_addr_cur = 8'h20;
    bus.d_addr = 8'h90; bus.d_we = 1'b0; d_hold = ref_arr[8'h90]; d_q.push_back(d_hold);
    bus.i_addr = 8'h20; i_q.push_back(ref_arr[8'h20]);
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    dc = -1; ic = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.d_ack) begin dc = k; bus.d_req = 1'b0; end
      if (bus.i_ack) begin ic = k; bus.i_req = 1'b0; end
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    check("collision_d_ack_cycle", 32'(dc), 2);
    check("collision_i_ack_cycle", 32'(ic), 5);
    idle(2);

    // Stray mem_ack while IDLE: no ack, no access, normal service afterwards
    stray_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stray_i_ack", 32'(bus.i_ack), 0);
      check("stray_d_ack", 32'(bus.d_ack), 0);
      check("stray_mem_req", 32'(bus.mem_req), 0);
    end
    do_i(8'h33, c0);
    idle(2);

    // Continuous contention: grant pattern depends on round-robin option
    txn_log.delete();
    fork
      begin
        while (txn_log.size() < 6) do_d(1'b0, 8'($urandom_range(128, 255)), 8'h00, c1);
      end
      begin
        bus.i_req = 1'b1;
        while (txn_log.size() < 6) do_i(8'($urandom_range(0, 127)), c2);
      end
    join
    check("starve_log_size", 32'(txn_log.size() >= 6), 1);
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      if (k < txn_log.size()) begin
        logic [7:0] a;
        a = txn_log[k];
        check("starve_grant_side", 32'(a[7]), 32'(exp_d));
      end
    end
    idle(4);

    // Reset during BUSY_D aborts the access at once
    mem_delay_force = 1000;
    d_addr_cur = 8'h85; d_we_cur = 1'b0;
    bus.d_addr = 8'h85; bus.d_we = 1'b0; bus.d_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_req) break;
    end
    check("rst_mid_mem_req_up", 32'(bus.mem_req), 1);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 0);
    check("rst_mid_d_ack", 32'(bus.d_ack), 0);
    check("rst_mid_stall_a", 32'(bus.stall_a), 0);
    check("rst_mid_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mid_d_rdata", 32'(bus.d_rdata), 0);
    d_q.delete();
    d_hold = 8'h00;
    bus.d_req = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    mem_delay_force = -1;
    txn_log.delete();
    idle(1);
    do_i(8'h12, c0);
    check("post_rst_txn_count", 32'(txn_log.size()), 1);
    if (txn_log.size() > 0) check("post_rst_first_mem_addr", 32'(txn_log[0]), 32'h12);
    idle(2);

    // Randomised traffic on both sides, random memory latency
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          idle(int'($urandom_range(0, 3)));
          do_i(8'($urandom_range(0, 127)), c1);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          idle(int'($urandom_range(0, 3)));
          do_d(1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), 8'($urandom), c2);
        end
      end
    join
    idle(4);
    check("i_queue_drained", 32'(i_q.size()), 0);
    check("d_queue_drained", 32'(d_q.size()), 0);
    check("idle_mem_req", 32'(bus.mem_req), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle backing-memory port between the fetch stage (instruction reads) and the action stage (data reads and writes) of the pipelined NAND CPU.
- Sits between the fetch/i_cache side and the d_cache side, and the single external memory.
- Sequences each access with a four-state FSM.
- Drives stall signals so the pipeline registers hold while a requester waits.

Parameters:
- ADDR_W, 8, address width of both requesters and the memory port.
- DATA_W, 8, data width; instructions and data words are both DATA_W.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- i_req  in  1  fetch read request; held high until i_ack
- i_addr  in  ADDR_W  fetch address; stable while i_req is high
- i_ack  out  1  one-cycle pulse; i_rdata is valid in that cycle
- i_rdata  out  DATA_W  fetched instruction; held until the next i_ack
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  read data; held until the next d_ack read
- mem_req  out  1  level request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_ack  in  1  one-cycle; mem_rdata valid with it
- mem_rdata  in  DATA_W  memory read data
- stall_f  out  1  hold fetch stage and i2d register
- stall_a  out  1  hold action stage and a2w register

Behaviour:
- Clock and reset: single clock clk. n_rst is asynchronous and active-low. All state and outputs reset immediately on n_rst low.
- Reset values: state=IDLE, all acks 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0, last_grant=I.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Grant a pending request. d_req wins over i_req by default.
  - On grant, latch the address (and d_we/d_wdata for a data grant) into the mem_* registers and assert mem_req at the next edge.
  - Go to BUSY_I or BUSY_D.
- BUSY_x:
  - mem_req=1; mem_addr, mem_we and mem_wdata stay constant.
  - On mem_ack: capture mem_rdata into x_rdata (reads only), drop mem_req, pulse x_ack at the next edge, go to RESP.
  - No memory-side timeout.
- RESP:
  - Lasts exactly one cycle; the ack pulse is visible here.
  - The arbiter ignores all requests in RESP, so the requester has one cycle to drop or change req. Then return to IDLE.
- Minimum latency: request seen in IDLE at cycle 0, mem_req at cycle 1, mem_ack at cycle 1 earliest, ack at cycle 2.
- stall_f = i_req & ~i_ack (combinational). stall_a = d_req & ~d_ack. Both are 0 in reset.
- Writes: d_rdata is unchanged; d_ack still pulses.
- Simultaneous i_req and d_req in IDLE: data is granted. Fetch is served on the next IDLE cycle.
- A request that rises while the other side is busy waits, and is served in the IDLE cycle after RESP.
- A requester that drops req while BUSY is a protocol violation. The access completes and its ack is still produced.
- mem_ack outside BUSY is ignored.
- Reset mid-access: the FSM aborts to IDLE and mem_req drops immediately. Memory must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: a round-robin register last_grant (updated on each grant) picks the side not granted last when both request in IDLE. Under continuous d_req, fetch is therefore guaranteed every second access.
- Undefined: fixed data-over-fetch priority; last_grant is not implemented.

Test Plan:
- Reset: n_rst low mid-BUSY_D with mem_req=1 -> mem_req, d_ack and stall_a are 0 in the same cycle, state is IDLE; after release and i_req, the first mem_addr equals i_addr.
- Single fetch: i_req=1, i_addr=0x12, memory acks 3 cycles later with rdata 0xA5 -> i_ack one cycle after mem_ack, i_rdata=0xA5, stall_f high until i_ack.
- Data write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x3C -> mem_we=1, mem_addr=0x40, mem_wdata=0x3C held until mem_ack; d_ack pulses; d_rdata unchanged.
- Collision: i_req and d_req rise together, zero-wait memory -> data served first (d_ack at cycle 2), fetch after (i_ack at cycle 5); no overlapping mem_req.
- Starvation (MEM_ARB_RR_EN defined): d_req held high for 6 accesses with i_req high -> grants alternate D,I,D,I. Without the macro: all D until d_req drops.
- Late ack: mem_ack pulsed while IDLE -> no ack output, no state change.
